// File: rtl/counter_run_ctrl_if.sv
// Command handshake between the board-level command source and the run controller.
// The source drives valid/op/data; the controller answers with ready.
interface counter_run_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/counter_run_ctrl.sv
// Single-clock run controller for the 4-bit display counter: a prescaler produces
// one-cycle step ticks, and an IDLE/RUN/PAUSE/DONE sequencer obeys valid/ready commands.
module counter_run_ctrl #(
    parameter logic [25:0] PRESCALE    = 26'd49_999_999,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_run_ctrl_if.slave    cmd,
    input  logic                 dir_i,
    input  logic [3:0]           limit_i,
    output logic                 tick_o,
    output logic [3:0]           counter_o,
    output logic [1:0]           state_o,
    output logic                 done_o
);
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_PAUSE = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    logic [1:0]  state_q,     state_d;
    logic [3:0]  counter_q,   counter_d;
    logic [3:0]  start_val_q, start_val_d;
    logic [25:0] presc_q,     presc_d;
    logic        tick_q,      tick_d;
    logic        done_q,      done_d;

    logic step;
    logic accept;

    // Commands are refused on the step edge so a command and a step never collide.
    assign step          = (state_q == ST_RUN) && (presc_q == PRESCALE);
    assign cmd.cmd_ready = ~step;
    assign accept        = cmd.cmd_valid & ~step;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        start_val_d = start_val_q;
        presc_d     = presc_q;
        tick_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_RUN:   presc_d = step ? 26'd0 : presc_q + 26'd1;
            ST_PAUSE: presc_d = presc_q;
            default:  presc_d = 26'd0;
        endcase

        if (step) begin
            tick_d = 1'b1;
            if (counter_q == limit_i) begin
                done_d = 1'b1;
                if (AUTO_RELOAD) counter_d = start_val_q;
                else             state_d   = ST_DONE;
            end else begin
                counter_d = dir_i ? counter_q + 4'd1 : counter_q - 4'd1;
            end
        end

        if (accept) begin
            case (cmd.cmd_op)
                OP_START: begin
                    state_d   = ST_RUN;
                    counter_d = start_val_q;
                    presc_d   = 26'd0;
                end
                OP_STOP: begin
                    if (state_q != ST_IDLE) begin
                        state_d   = ST_IDLE;
                        counter_d = start_val_q;
                        presc_d   = 26'd0;
                    end
                end
                OP_PAUSE: begin
                    if (state_q == ST_RUN)        state_d = ST_PAUSE;
                    else if (state_q == ST_PAUSE) state_d = ST_RUN;
                end
                OP_LOAD: begin
                    start_val_d = cmd.cmd_data;
                    if (state_q == ST_IDLE) counter_d = cmd.cmd_data;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            counter_q   <= 4'd0;
            start_val_q <= 4'd0;
            presc_q     <= 26'd0;
            tick_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            start_val_q <= start_val_d;
            presc_q     <= presc_d;
            tick_q      <= tick_d;
            done_q      <= done_d;
        end
    end

    assign tick_o    = tick_q;
    assign counter_o = counter_q;
    assign state_o   = state_q;
    assign done_o    = done_q;
endmodule

// File: tb/tb_counter_run_ctrl.sv
// Bench for counter_run_ctrl: two instances (stop-at-limit and auto-reload) share one
// stimulus stream and are compared every cycle against a cycle-level behavioural model.
module tb_counter_run_ctrl;
    localparam int P = 3;
    localparam int IDLE = 0, RUN = 1, PAUSE = 2, DONE = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       valid;
    logic [1:0] op;
    logic [3:0] data;
    logic       dir;
    logic [3:0] limit;

    counter_run_ctrl_if bus0 ();
    counter_run_ctrl_if bus1 ();
    assign bus0.cmd_valid = valid;
    assign bus0.cmd_op    = op;
    assign bus0.cmd_data  = data;
    assign bus1.cmd_valid = valid;
    assign bus1.cmd_op    = op;
    assign bus1.cmd_data  = data;

    logic       tick_w  [2];
    logic [3:0] cnt_w   [2];
    logic [1:0] st_w    [2];
    logic       done_w  [2];
    logic       ready_w [2];
    assign ready_w[0] = bus0.cmd_ready;
    assign ready_w[1] = bus1.cmd_ready;

    counter_run_ctrl #(.PRESCALE(26'd3), .AUTO_RELOAD(1'b0)) u_stop (
        .clk(clk), .rst(rst), .cmd(bus0), .dir_i(dir), .limit_i(limit),
        .tick_o(tick_w[0]), .counter_o(cnt_w[0]), .state_o(st_w[0]), .done_o(done_w[0])
    );
    counter_run_ctrl #(.PRESCALE(26'd3), .AUTO_RELOAD(1'b1)) u_reload (
        .clk(clk), .rst(rst), .cmd(bus1), .dir_i(dir), .limit_i(limit),
        .tick_o(tick_w[1]), .counter_o(cnt_w[1]), .state_o(st_w[1]), .done_o(done_w[1])
    );

    int checks = 0;
    int errors = 0;

    // Reference model: elapsed cycles in the current tick period, plus the visible outputs.
    int m_state [2];
    int m_cnt   [2];
    int m_start [2];
    int m_phase [2];
    bit m_tick  [2];
    bit m_done  [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready(input int i);
        return !(m_state[i] == RUN && m_phase[i] == P);
    endfunction

    // One clock: predict from pre-edge inputs, advance, then compare both instances.
    task automatic cyc();
        int ns [2]; int nc [2]; int nst [2]; int np [2]; bit nt [2]; bit nd [2];
        for (int i = 0; i < 2; i++) begin
            bit stepping;
            stepping = !m_ready(i);
            nt[i] = 0; nd[i] = 0;
            ns[i] = m_state[i]; nc[i] = m_cnt[i]; nst[i] = m_start[i]; np[i] = m_phase[i];
            if (rst) begin
                ns[i] = IDLE; nc[i] = 0; nst[i] = 0; np[i] = 0;
            end else begin
                if (stepping) begin
                    nt[i] = 1; np[i] = 0;
                    if (m_cnt[i] == int'(limit)) begin
                        nd[i] = 1;
                        if (i == 1) nc[i] = m_start[i];
                        else        ns[i] = DONE;
                    end else begin
                        nc[i] = dir ? (m_cnt[i] + 1) % 16 : (m_cnt[i] + 15) % 16;
                    end
                end else if (m_state[i] == RUN) np[i] = m_phase[i] + 1;
                else if (m_state[i] != PAUSE)   np[i] = 0;
                if (valid && !stepping) begin
                    case (op)
                        2'd0: begin ns[i] = RUN; nc[i] = m_start[i]; np[i] = 0; end
                        2'd1: if (m_state[i] != IDLE) begin
                                  ns[i] = IDLE; nc[i] = m_start[i]; np[i] = 0;
                              end
                        2'd2: if (m_state[i] == RUN) ns[i] = PAUSE;
                              else if (m_state[i] == PAUSE) ns[i] = RUN;
                        default: begin
                            nst[i] = int'(data);
                            if (m_state[i] == IDLE) nc[i] = int'(data);
                        end
                    endcase
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            m_state[i] = ns[i]; m_cnt[i] = nc[i]; m_start[i] = nst[i];
            m_phase[i] = np[i]; m_tick[i] = nt[i]; m_done[i] = nd[i];
            check($sformatf("u%0d.state", i),   st_w[i],    m_state[i]);
            check($sformatf("u%0d.counter", i), cnt_w[i],   m_cnt[i]);
            check($sformatf("u%0d.tick", i),    tick_w[i],  m_tick[i]);
            check($sformatf("u%0d.done", i),    done_w[i],  m_done[i]);
            check($sformatf("u%0d.ready", i),   ready_w[i], m_ready(i));
        end
    endtask

    // Issue a command, held until the stop-at-limit instance accepts it (bounded).
    task automatic cmd(input logic [1:0] o, input logic [3:0] d);
        bit accepted = 0;
        valid = 1'b1; op = o; data = d;
        for (int n = 0; n < 8 && !accepted; n++) begin
            accepted = m_ready(0);
            cyc();
        end
        valid = 1'b0;
        check("cmd_accepted", accepted, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(); rst = 1'b0;
    endtask

    // Run one full tick period on instance k and check the step it produces.
    task automatic tick_step(input int k, input logic [3:0] exp_cnt, input logic exp_done);
        for (int n = 0; n < P; n++) begin
            cyc();
            check("no_tick_between", tick_w[k], 1'b0);
        end
        cyc();
        check("tick_at_period",  tick_w[k], 1'b1);
        check("counter_at_tick", cnt_w[k],  exp_cnt);
        check("done_at_tick",    done_w[k], exp_done);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; op = 2'd0; data = 4'd0; dir = 1'b1; limit = 4'd8;
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0; m_cnt[i] = 0; m_start[i] = 0; m_phase[i] = 0;
            m_tick[i] = 0; m_done[i] = 0;
        end
        cyc(); cyc();
        rst = 1'b0;

        // Reset mid-RUN overrides a simultaneous START.
        cmd(2'd3, 4'd3); cmd(2'd0, 4'd0);
        repeat (5) cyc();
        valid = 1'b1; op = 2'd0; rst = 1'b1;
        cyc();
        rst = 1'b0; valid = 1'b0;
        check("rst_state", st_w[0], 2'b00);
        check("rst_counter", cnt_w[0], 4'd0);
        check("rst_tick", tick_w[0], 1'b0);
        check("rst_done", done_w[0], 1'b0);
        check("rst_ready", ready_w[0], 1'b1);

        // Count up 5..8, done one period after 8, then hold in DONE.
        dir = 1'b1; limit = 4'd8;
        cmd(2'd3, 4'd5);
        check("load_idle_counter", cnt_w[0], 4'd5);
        cmd(2'd0, 4'd0);
        check("start_counter", cnt_w[0], 4'd5);
        tick_step(0, 4'd6, 1'b0);
        tick_step(0, 4'd7, 1'b0);
        tick_step(0, 4'd8, 1'b0);
        tick_step(0, 4'd8, 1'b1);
        check("done_state", st_w[0], 2'b11);
        repeat (6) cyc();
        check("done_hold_counter", cnt_w[0], 4'd8);
        check("done_hold_state", st_w[0], 2'b11);

        // Wrap upward 14,15,0,1 then downward 1,0,15,14.
        do_reset();
        limit = 4'd1; dir = 1'b1;
        cmd(2'd3, 4'd14); cmd(2'd0, 4'd0);
        tick_step(0, 4'd15, 1'b0); tick_step(0, 4'd0, 1'b0);
        tick_step(0, 4'd1, 1'b0);  tick_step(0, 4'd1, 1'b1);
        check("wrap_up_done_state", st_w[0], 2'b11);
        do_reset();
        limit = 4'd14; dir = 1'b0;
        cmd(2'd3, 4'd1); cmd(2'd0, 4'd0);
        tick_step(0, 4'd0, 1'b0);  tick_step(0, 4'd15, 1'b0);
        tick_step(0, 4'd14, 1'b0); tick_step(0, 4'd14, 1'b1);
        check("wrap_down_done_state", st_w[0], 2'b11);

        // Auto-reload 2,3,4,2,... with done on every third tick, state stays RUN.
        do_reset();
        limit = 4'd4; dir = 1'b1;
        cmd(2'd3, 4'd2); cmd(2'd0, 4'd0);
        for (int r = 0; r < 2; r++) begin
            tick_step(1, 4'd3, 1'b0);
            tick_step(1, 4'd4, 1'b0);
            tick_step(1, 4'd2, 1'b1);
            check("reload_state_run", st_w[1], 2'b01);
        end

        // Pause at prescaler=1, hold 20 clocks, resume: tick exactly 2 clocks later.
        do_reset();
        limit = 4'd15; dir = 1'b1;
        cmd(2'd0, 4'd0);
        cyc();
        cmd(2'd2, 4'd0);
        check("pause_state", st_w[0], 2'b10);
        for (int n = 0; n < 20; n++) begin
            cyc();
            check("pause_frozen_counter", cnt_w[0], 4'd0);
            check("pause_no_tick", tick_w[0], 1'b0);
        end
        cmd(2'd2, 4'd0);
        check("resume_state", st_w[0], 2'b01);
        cyc();
        check("resume_no_tick_yet", tick_w[0], 1'b0);
        cyc();
        check("resume_tick", tick_w[0], 1'b1);
        check("resume_counter", cnt_w[0], 4'd1);

        // START held across the not-ready cycle is accepted one cycle later.
        cyc(); cyc(); cyc();
        valid = 1'b1; op = 2'd0;
        check("ready_low_on_step", ready_w[0], 1'b0);
        cyc();
        check("step_while_held_tick", tick_w[0], 1'b1);
        check("ready_back_high", ready_w[0], 1'b1);
        cyc();
        valid = 1'b0;
        check("held_start_restart", cnt_w[0], 4'd0);

        // Commands in RUN, then START from DONE.
        do_reset();
        limit = 4'd10; dir = 1'b1;
        cmd(2'd3, 4'd5); cmd(2'd0, 4'd0); cyc();
        cmd(2'd3, 4'd9);
        check("run_load_counter_kept", cnt_w[0], 4'd5);
        cmd(2'd1, 4'd0);
        check("stop_state", st_w[0], 2'b00);
        check("stop_counter", cnt_w[0], 4'd9);
        cmd(2'd0, 4'd0);
        tick_step(0, 4'd10, 1'b0);
        tick_step(0, 4'd10, 1'b1);
        cmd(2'd0, 4'd0);
        check("done_start_counter", cnt_w[0], 4'd9);
        check("done_start_state", st_w[0], 2'b01);
        tick_step(0, 4'd10, 1'b0);

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rst   = ($urandom_range(0, 63) == 0);
            valid = ($urandom_range(0, 3) == 0);
            op    = 2'($urandom);
            data  = 4'($urandom);
            if ($urandom_range(0, 15) == 0) dir   = 1'($urandom);
            if ($urandom_range(0, 15) == 0) limit = 4'($urandom);
            cyc();
        end
        rst = 1'b0; valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/counter_run_ctrl.md
Name: counter_run_ctrl

Overview:
- Single-clock run controller for the 4-bit display counter.
- Replaces derived-clock counting with a programmable prescaler that produces a one-cycle enable tick.
- Sequences the counter through IDLE/RUN/PAUSE/DONE under a valid/ready command interface, with load, direction and terminal-limit control.
- Sits between the board-level command source (buttons/UART decoder) and the counter display.

Parameters:
- PRESCALE, 26'd49_999_999: tick period is PRESCALE+1 clk cycles; legal range 1..2^26-1.
- AUTO_RELOAD, 0: 1 = reload start value at limit and keep running; 0 = stop in DONE.

Ports:
- clk  input  1  system clock; the only clock in the block.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  input  2  command: 00 START, 01 STOP, 10 PAUSE (toggles pause/resume), 11 LOAD.
- cmd_data  input  4  LOAD value.
- dir  input  1  1 = count up, 0 = count down; sampled on each tick.
- limit  input  4  terminal count; sampled on each tick.
- tick  output  1  one-cycle pulse, coincident with each counter step.
- counter  output  4  current count.
- state  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE.
- done  output  1  one-cycle pulse when the limit is processed.

Behaviour:
- Reset (clk edge with rst=1) forces: state IDLE, counter 0, start_val 0, prescaler 0, tick 0, done 0. Reset overrides any command in the same cycle.
- Internal registers: start_val[3:0] and prescaler[25:0].
- Prescaler in RUN:
  - Increments each cycle.
  - At PRESCALE it wraps to 0 and a step occurs on that edge.
  - tick, the counter update and any done are all registered and visible in the following cycle.
- Prescaler outside RUN: held in PAUSE; cleared to 0 in IDLE and DONE.
- cmd_ready is combinational: 0 when state==RUN and prescaler==PRESCALE, else 1. A command and a step therefore never occur on the same edge. A command held valid through a not-ready cycle is accepted in the next cycle.
- Step rule, on the step edge:
  - If counter==limit: done<=1. With AUTO_RELOAD=1, counter<=start_val and state stays RUN. With AUTO_RELOAD=0, counter is held and state<=DONE.
  - Else counter <= counter+1 (dir=1) or counter-1 (dir=0), modulo 16 (15->0 up, 0->15 down).
  - tick<=1 in both cases.
- The limit value is therefore displayed for one full tick period before done. A limit unreachable in the chosen direction is still reached via wrap-around.
- Commands, by state (all accepted commands take effect on the accepting edge):
  - IDLE:
    - START -> RUN; counter<=start_val; prescaler<=0.
    - LOAD -> start_val<=cmd_data and counter<=cmd_data.
    - STOP and PAUSE: no effect.
  - RUN:
    - PAUSE -> PAUSE.
    - STOP -> IDLE; counter<=start_val.
    - START -> restart (counter<=start_val, prescaler<=0).
    - LOAD -> start_val<=cmd_data only; counter unchanged.
  - PAUSE:
    - PAUSE -> RUN; prescaler resumes from its held value.
    - STOP -> IDLE; counter<=start_val.
    - START -> RUN restart.
    - LOAD -> start_val only.
  - DONE:
    - START -> RUN restart.
    - STOP -> IDLE; counter<=start_val.
    - LOAD -> start_val only.
    - PAUSE: no effect.
- tick and done are 0 in every cycle not following a step edge.

Test Plan (PRESCALE=3 unless noted):
- Reset: assert rst mid-RUN with cmd_valid=1 START -> next cycle state=00, counter=0, tick=0, done=0, cmd_ready=1.
- LOAD 4'd5 in IDLE, START, dir=1, limit=8 -> counter 5,6,7,8 with tick every 4 clks; done pulses one period after counter reaches 8; state=11; counter holds 8.
- Wrap: LOAD 14, START, dir=1, limit=1 -> counter 14,15,0,1, done, DONE. Repeat with dir=0 from 1, limit 14 -> 1,0,15,14.
- AUTO_RELOAD=1, LOAD 2, limit 4 -> 2,3,4,2,3,4…; done every 3rd tick; state stays 01.
- Pause/handshake: PAUSE when prescaler=1 -> counter frozen 20 clks; resume -> next tick exactly 2 clks later. Hold START valid on the prescaler==3 cycle -> cmd_ready=0 that cycle; accepted next cycle.
- Commands in RUN: LOAD 9 -> counter unaffected; STOP -> IDLE with counter=9. START from DONE -> counter=9, RUN, first tick after 4 clks.
